// File: rtl/varredura_display_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | varredura_display_pkg : scan states and active-low segment codes |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package varredura_display_pkg;

  typedef enum logic [1:0] {
    UNI    = 2'd0,
    GAP_UD = 2'd1,
    DEZ    = 2'd2,
    GAP_DU = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  // Index 15 first: codes 10..15 render as a dash
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
    7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

endpackage
`default_nettype wire

// File: rtl/varredura_display_decod_7seg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decod_7seg : BCD to active-low seven-segment, dash for 10..15    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module decod_7seg
  import varredura_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[bcd];

endmodule
`default_nettype wire

// File: rtl/varredura_display.sv
`default_nettype none
// +------------------------------------------------------------------+
// | varredura_display : two-digit multiplexed 7-seg scanner w/ blink |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module varredura_display
  import varredura_display_pkg::*;
#(
  parameter int DIV         = 50000,
  parameter int BLINK_SLOTS = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] unidade,
  input  logic [3:0] dezena,
  input  logic       blank_zero,
  input  logic       piscar,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int PW = $clog2(DIV);
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);

  logic [3:0]    snap_uni;
  logic [3:0]    snap_dez;
  logic [PW-1:0] prescale;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          tick;
  logic          in_gap;
  logic          dark;
  state_t        state;
  state_t        state_next;
  logic [3:0]    digit_sel;
  logic [6:0]    seg_dec;
  logic [1:0]    an_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_uni <= 4'd0;
      snap_dez <= 4'd0;
    end else if (load) begin
      snap_uni <= unidade;
      snap_dez <= dezena;
    end
  end

  assign in_gap = (state == GAP_UD) || (state == GAP_DU);
  assign tick   = (prescale == PRE_LAST);

  // Prescaler pauses in the gap cycles so each digit stays lit for a full DIV cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (!in_gap) begin
      prescale <= tick ? '0 : prescale + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= UNI;
    else       state <= state_next;
  end

  assign dark = piscar & ~phase;

  always_comb begin
    state_next = state;
    an_next    = 2'b11;
    case (state)
      UNI: begin
        if (tick) state_next = GAP_UD;
        if (!dark) an_next = 2'b10;
      end
      GAP_UD: state_next = DEZ;
      DEZ: begin
        if (tick) state_next = GAP_DU;
        if (!dark && !(blank_zero && (snap_dez == 4'd0))) an_next = 2'b01;
      end
      GAP_DU: state_next = UNI;
      default: state_next = UNI;
    endcase
  end

  assign digit_sel = (state == DEZ) ? snap_dez : snap_uni;

  decod_7seg u_decod (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

  // seg only refreshes while the pins are dark, so a lit digit never shows mixed data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= 2'b11;
    end else begin
      an <= an_next;
      if (an == 2'b11) seg <= seg_dec;
    end
  end

endmodule
`default_nettype wire

// File: doc/varredura_display.md
VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 Parameter DIV, default 50000: refresh prescaler; clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLINK_SLOTS, default 256: digit slots per blink half-period; legal range 1..2^16.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  snapshot strobe; when 1, unidade/dezena are captured.
REQ-006 unidade  input  4  BCD units digit from the 0-99 counter (M3..M0 order, bit 3 = MSB).
REQ-007 dezena  input  4  BCD tens digit from the 0-99 counter (S3..S0 order, bit 3 = MSB).
REQ-008 blank_zero  input  1  when 1, a tens digit of 0 is suppressed.
REQ-009 piscar  input  1  when 1, the display blinks.
REQ-010 seg  output  7  segments a..g as seg[6]..seg[0], active-low, registered.
REQ-011 an  output  2  digit enables, an[0] = units, an[1] = tens, active-low, registered.

Function
REQ-012 On a rising edge with load=1, the snapshot registers SHALL take unidade and dezena; with load=0 they SHALL hold.
REQ-013 The prescaler SHALL count 0..DIV-1 and wrap; a tick SHALL be asserted for the one cycle in which the count equals DIV-1.
REQ-014 The FSM SHALL have the states UNI, GAP_UD, DEZ and GAP_DU; reset state is UNI.
REQ-015 Transitions:
  - UNI -> GAP_UD on tick.
  - GAP_UD -> DEZ unconditionally after 1 cycle.
  - DEZ -> GAP_DU on tick.
  - GAP_DU -> UNI unconditionally after 1 cycle.
REQ-016 During GAP_* states, an SHALL be 2'b11; this is the anti-ghosting interval.
REQ-017 In UNI, an SHALL be 2'b10 and seg SHALL encode the units snapshot; in DEZ, an SHALL be 2'b01 and seg SHALL encode the tens snapshot.
REQ-018 seg and an SHALL be registered outputs: one cycle of latency from the state/snapshot to the pins; seg SHALL never change while the enabled digit is unchanged.
REQ-019 Encoding (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Codes 10..15 SHALL display a dash (1111110).
REQ-020 If blank_zero=1 and the tens snapshot is 0, an SHALL be 2'b11 in DEZ; the units digit is never suppressed.
REQ-021 The blink counter SHALL count ticks 0..BLINK_SLOTS-1; each wrap SHALL toggle the phase bit, and the phase bit SHALL be 1 after reset.
REQ-022 With piscar=1 and phase=0, an SHALL be 2'b11 in every state; with piscar=0, the phase SHALL be ignored while the counter keeps running.
REQ-023 A load coincident with a tick SHALL let the new snapshot be displayed from the next enabled slot onward; no digit shows mixed data.
REQ-024 Changing blank_zero or piscar SHALL take effect on the next registered output update, with no FSM perturbation.

Reset
REQ-025 While reset=1:
  - seg = 7'b1111111 and an = 2'b11.
  - snapshot = 0/0, prescaler = 0, blink counter = 0, phase = 1, state = UNI.
REQ-026 Reset asserted mid-slot SHALL immediately force the REQ-025 values; after release, the first tick SHALL occur DIV cycles later.
REQ-027 After release with load=0, the display SHALL show 00 (or 0 with blank_zero=1).

Structure
REQ-028 The shared package SHALL hold:
  - the 4 FSM state encodings,
  - the 16-entry active-low segment table,
  - the SEG_OFF (1111111) and SEG_DASH (1111110) constants.
REQ-029 One sub-module, decod_7seg (combinational BCD to active-low segments, dash for 10..15), SHALL be instantiated once, fed by a mux of the snapshot registers.

Verification (DIV=4, BLINK_SLOTS=2)
REQ-030 Load unidade=7, dezena=3 -> an alternates 10/11/01/11; seg = 0001111 while an=10 and 0000110 while an=01; each digit is held 4 cycles with a 1-cycle gap.
REQ-031 blank_zero=1 with dezena=0, unidade=5 -> an never equals 01; seg = 0100100 while an=10; blank_zero=0 -> tens shows 0000001.
REQ-032 unidade=4'hC, dezena=9 -> units slot shows 1111110 and tens slot shows 0000100.
REQ-033 piscar=1 -> an = 11 for 2 full slots, then normal scanning for 2 slots, repeating; piscar=0 -> no dark slots.
REQ-034 Assert reset during a DEZ slot with snapshot 42 -> seg=1111111 and an=11 within the same cycle; after release, 00 is displayed and the first tick occurs 4 cycles later.
REQ-035 Toggle load coincident with tick while changing 12 -> 34 -> no slot shows 1 and 4 together or 3 and 2 together.
